pipe_generator: RTL and testbench

Produces the scrolling pipe that the collision checker tests the bird against. It moves one pipe leftward once per frame, respawns it at the right screen edge with a pseudo-random gap height, and counts passed pipes as the score. It consumes the one-hot game state (Q_Initial / Q_Check / Q_Lose) and drives X_Edge_Left, X_Edge_Right, Y_Edge_Top and Y_Edge_Bottom into the collision logic and the VGA renderer.

---
 rtl/flappy_pkg.sv | 27 ++
 rtl/lfsr10.sv | 16 +
 rtl/pipe_generator.sv | 126 ++++++++++++
 tb/tb_pipe_generator.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/flappy_pkg.sv
// Shared constants for the flappy datapath.
// State codes match the collision checker.
package flappy_pkg;
  localparam logic [2:0] QInitial = 3'b001;
  localparam logic [2:0] QCheck   = 3'b010;
  localparam logic [2:0] QLose    = 3'b100;

  localparam int ScreenW = 640;
  localparam int ScreenH = 480;
  localparam int PipeW   = 60;
  localparam int GapH    = 140;
  localparam int GapMin  = 80;
  localparam int GapBits = 7;
  localparam int Speed   = 2;

  localparam logic [9:0] LfsrSeed = 10'h2A5;

  typedef enum logic [1:0] {
    IDLE,
    SCROLL,
    FROZEN
  } pipe_state_e;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/lfsr10.sv
// Free-running 10-bit Fibonacci LFSR, x^10 + x^7 + 1.
// Recovers to the seed if it ever lands on zero.
import flappy_pkg::*;

module lfsr10 (
  input  logic       Clk,
  input  logic       reset,
  output logic [9:0] q
);
  always_ff @(posedge Clk) begin
    if (reset || q == '0)
      q <= LfsrSeed;
    else
      q <= {q[8:0], q[9] ^ q[6]};
  end
endmodule

// File: rtl/pipe_generator.sv
// Scrolling pipe: moves left per frame, respawns
// with a random gap, and scores passed pipes.
import flappy_pkg::*;

module pipe_generator #(
  parameter int SCREEN_W = ScreenW,
  parameter int PIPE_W   = PipeW,
  parameter int GAP_H    = GapH,
  parameter int GAP_MIN  = GapMin,
  parameter int GAP_BITS = GapBits,
  parameter int SPEED    = Speed
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       Frame_Tick,
  input  logic       Q_Initial,
  input  logic       Q_Check,
  input  logic       Q_Lose,
  input  logic [9:0] Bird_X_L,
  output logic [9:0] X_Edge_Left,
  output logic [9:0] X_Edge_Right,
  output logic [9:0] Y_Edge_Top,
  output logic [9:0] Y_Edge_Bottom,
  output logic [7:0] Score,
  output logic       Pipe_Passed
);
  localparam logic signed [10:0] SpawnL = 11'(SCREEN_W);
  localparam logic [9:0] SpawnR   = 10'(SCREEN_W + PIPE_W);
  localparam int         MidTop   = GAP_MIN + 2 ** (GAP_BITS - 1);
  localparam logic [9:0] SpawnTop = 10'(MidTop);
  localparam logic [9:0] SpawnBot = 10'(MidTop + GAP_H);

  pipe_state_e        state;
  logic signed [10:0] pos_l;
  logic signed [10:0] nxt_l;
  logic [9:0]         nxt_r;
  logic [9:0]         nxt_left;
  logic [9:0]         rnd_top;
  logic [9:0]         lfsr;
  logic               respawn;
  logic               score_ev;
  logic               passed;
  logic               reload;
  logic               move;

  lfsr10 u_lfsr (
    .Clk   (Clk),
    .reset (reset),
    .q     (lfsr)
  );

  wire unused_lfsr = ^lfsr;

  always_comb begin
    respawn  = X_Edge_Right <= 10'(SPEED);
    nxt_l    = respawn ? SpawnL : pos_l - 11'(SPEED);
    nxt_r    = 10'(nxt_l + 11'(PIPE_W));
    nxt_left = nxt_l[10] ? '0 : nxt_l[9:0];
    rnd_top  = 10'(GAP_MIN) + 10'(lfsr[GAP_BITS-1:0]);
    score_ev = (X_Edge_Right >= Bird_X_L) &&
               (nxt_r < Bird_X_L) && !passed;
    reload   = (state != IDLE) && Q_Initial;
    // Q_Lose wins over a tick landing on the same edge
    move     = (state == SCROLL) && !Q_Initial &&
               !Q_Lose && Frame_Tick;
  end

  always_ff @(posedge Clk) begin
    if (reset || reload) begin
      pos_l         <= SpawnL;
      X_Edge_Left   <= SpawnL[9:0];
      X_Edge_Right  <= SpawnR;
      Y_Edge_Top    <= SpawnTop;
      Y_Edge_Bottom <= SpawnBot;
    end else if (move) begin
      pos_l        <= nxt_l;
      X_Edge_Left  <= nxt_left;
      X_Edge_Right <= nxt_r;
      if (respawn) begin
        Y_Edge_Top    <= rnd_top;
        Y_Edge_Bottom <= rnd_top + 10'(GAP_H);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state       <= IDLE;
      Score       <= '0;
      Pipe_Passed <= 1'b0;
      passed      <= 1'b0;
    end else begin
      Pipe_Passed <= 1'b0;
      if (reload) begin
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (Q_Check) begin
              state  <= SCROLL;
              Score  <= '0;
              passed <= 1'b0;
            end
          end
          SCROLL: begin
            if (Q_Lose) begin
              state <= FROZEN;
            end else if (Frame_Tick) begin
              if (score_ev) begin
                Score       <= sat_inc(Score);
                Pipe_Passed <= 1'b1;
                passed      <= 1'b1;
              end else if (respawn) begin
                passed <= 1'b0;
              end
            end
          end
          FROZEN: begin
            state <= FROZEN;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_pipe_generator.sv
// Directed bench for pipe_generator with a score
// scoreboard; a fast-scroll instance covers saturation.
module tb_pipe_generator;
  logic       clk = 1'b0;
  logic       rst;
  logic       ft0, ft1;
  logic       qi, qc, ql;
  logic [9:0] bird;
  logic [9:0] xl0, xr0, yt0, yb0;
  logic [9:0] xl1, xr1, yt1, yb1;
  logic [7:0] sc0, sc1;
  logic       pp0, pp1;

  int vectors = 0;
  int miscompares = 0;
  int pcount0 = 0;
  int pcount1 = 0;
  int m_r[2];
  int m_s[2];
  bit m_p[2];
  int q0[$];
  int q1[$];

  always #5 clk = ~clk;

  pipe_generator dut (
    .Clk(clk), .reset(rst), .Frame_Tick(ft0),
    .Q_Initial(qi), .Q_Check(qc), .Q_Lose(ql),
    .Bird_X_L(bird),
    .X_Edge_Left(xl0), .X_Edge_Right(xr0),
    .Y_Edge_Top(yt0), .Y_Edge_Bottom(yb0),
    .Score(sc0), .Pipe_Passed(pp0)
  );

  pipe_generator #(.SPEED(50)) dut_fast (
    .Clk(clk), .reset(rst), .Frame_Tick(ft1),
    .Q_Initial(qi), .Q_Check(qc), .Q_Lose(ql),
    .Bird_X_L(bird),
    .X_Edge_Left(xl1), .X_Edge_Right(xr1),
    .Y_Edge_Top(yt1), .Y_Edge_Bottom(yb1),
    .Score(sc1), .Pipe_Passed(pp1)
  );

  task automatic chk(string tag, int obs, int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_r[k] = 700;
      m_s[k] = 0;
      m_p[k] = 1'b0;
    end
  endtask

  task automatic model_step(int k);
    int spd;
    int nr;
    spd = (k == 0) ? 2 : 50;
    if (m_r[k] <= spd) begin
      m_r[k] = 700;
      m_p[k] = 1'b0;
    end else begin
      nr = m_r[k] - spd;
      if (m_r[k] >= 200 && nr < 200 && !m_p[k]) begin
        m_s[k] = (m_s[k] == 255) ? 255 : m_s[k] + 1;
        m_p[k] = 1'b1;
        if (k == 0) q0.push_back(m_s[k]);
        else q1.push_back(m_s[k]);
      end
      m_r[k] = nr;
    end
  endtask

  task automatic tick(int k, int n);
    repeat (n) begin
      model_step(k);
      if (k == 0) ft0 = 1'b1;
      else ft1 = 1'b1;
      cyc(1);
      ft0 = 1'b0;
      ft1 = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (pp0) begin
      pcount0++;
      chk("pp0_expected", int'(q0.size() > 0), 1);
      if (q0.size() > 0) chk("score0_sb", sc0, q0.pop_front());
    end
    if (pp1) begin
      pcount1++;
      chk("pp1_expected", int'(q1.size() > 0), 1);
      if (q1.size() > 0) chk("score1_sb", sc1, q1.pop_front());
    end
  end

  initial begin
    rst = 1'b1; ft0 = 0; ft1 = 0;
    qi = 0; qc = 0; ql = 0;
    bird = 10'd200;
    model_reset();
    cyc(2);
    rst = 1'b0;
    cyc(1);
    chk("rst_left", xl0, 640);
    chk("rst_right", xr0, 700);
    chk("rst_top", yt0, 144);
    chk("rst_bottom", yb0, 284);
    chk("rst_score", sc0, 0);
    chk("rst_pulse", pp0, 0);

    // tick on the IDLE->SCROLL edge must not move
    qc = 1'b1; ft0 = 1'b1;
    cyc(1);
    qc = 1'b0; ft0 = 1'b0;
    chk("enter_no_move", xr0, 700);

    tick(0, 251);
    chk("t251_right", xr0, 198);
    chk("t251_left", xl0, 138);
    chk("t251_score", sc0, 1);
    tick(0, 1);
    chk("t252_score", sc0, 1);
    chk("t252_pulses", pcount0, 1);
    chk("t252_right", xr0, m_r[0]);

    tick(0, 97);
    chk("t349_right", xr0, 2);
    chk("t349_left", xl0, 0);
    tick(0, 1);
    chk("resp_right", xr0, 700);
    chk("resp_left", xl0, 640);
    chk("resp_top_rng", int'(yt0 >= 80 && yt0 <= 207), 1);
    chk("resp_gap", int'(yb0) - int'(yt0), 140);

    tick(0, 5);
    chk("pre_freeze_r", xr0, 690);
    ql = 1'b1; ft0 = 1'b1;
    cyc(1);
    ql = 1'b0; ft0 = 1'b0;
    chk("freeze_right", xr0, 690);
    chk("freeze_left", xl0, 630);
    repeat (3) begin
      ft0 = 1'b1;
      cyc(1);
      ft0 = 1'b0;
      cyc(1);
    end
    chk("frozen_right", xr0, 690);
    chk("frozen_score", sc0, 1);

    qi = 1'b1;
    cyc(1);
    qi = 1'b0;
    chk("restart_right", xr0, 700);
    chk("restart_left", xl0, 640);
    chk("restart_top", yt0, 144);
    chk("restart_bot", yb0, 284);
    chk("restart_score", sc0, 1);
    qc = 1'b1;
    cyc(1);
    qc = 1'b0;
    model_reset();
    chk("check_clr", sc0, 0);

    tick(1, 260 * 14);
    cyc(1);
    chk("sat_score", sc1, 255);
    chk("sat_pulses", pcount1, 260);
    chk("sat_right", xr1, m_r[1]);
    chk("sb1_drained", q1.size(), 0);
    chk("sb0_drained", q0.size(), 0);

    tick(0, 10);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("midrst_right", xr0, 700);
    chk("midrst_score", sc1, 0);
    chk("midrst_pulse", pp1, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
